// File: rtl/axi2uart_pkg.sv
// Shared constants, state encodings and the read-response record for the AXI-to-UART bridge.
package axi2uart_pkg;
  localparam logic [31:0] REG_DATA   = 32'h00;
  localparam logic [31:0] REG_STATUS = 32'h10;

  localparam int ST_TX_CNT   = 0;
  localparam int ST_RX_CNT   = 16;
  localparam int ST_TX_FULL  = 32;
  localparam int ST_RX_EMPTY = 33;
  localparam int ST_RX_OVF   = 34;

  localparam int WB_FLUSH_TX = 0;
  localparam int WB_FLUSH_RX = 1;
  localparam int WB_CLR_OVF  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_GUARD, T_WAIT} tx_state_e;
  typedef enum logic [1:0] {SEL_DATA, SEL_STATUS, SEL_NONE} reg_sel_e;

  // Only the low 64 bits of a read can ever be non-zero; the top zero-extends.
  typedef struct packed {
    logic [1:0]  resp;
    logic [63:0] data;
  } rd_rsp_t;

  function automatic reg_sel_e decode(input logic [31:0] addr);
    if (addr == REG_DATA)   return SEL_DATA;
    if (addr == REG_STATUS) return SEL_STATUS;
    return SEL_NONE;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; flush overrides any push/pop in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     gclk,
  input  logic                     grst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge gclk)
    if (do_push && !flush) mem[wr_ptr] <= din;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/axi2uart_fifo.sv
// AXI4 slave: bursts to DATA feed the UART TX FIFO; reads pop the RX FIFO or return STATUS without blocking.
module axi2uart_fifo
  import axi2uart_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 6,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int TX_DEPTH       = 16,
  parameter int RX_DEPTH       = 16
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  input  logic                      tx_busy,
  input  logic                      rx_ready,
  input  logic [7:0]                rx_data
);
  localparam int TXC = $clog2(TX_DEPTH) + 1;
  localparam int RXC = $clog2(RX_DEPTH) + 1;

  wr_state_e wr_state, wr_next;
  rd_state_e rd_state, rd_next;
  tx_state_e tx_state, tx_next;
  reg_sel_e  wr_sel, ar_sel;
  logic [1:0] bresp_q;
  rd_rsp_t    rsp_q, rsp_d;
  logic       rx_overflow;

  logic           aw_hs, w_hs, ar_hs, status_beat;
  logic           tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic           rx_pop, rx_flush, rx_full, rx_empty, ovf_clr;
  logic [7:0]     tx_head, rx_head;
  logic [TXC-1:0] tx_count;
  logic [RXC-1:0] rx_count;
  logic           unused_ok;

  assign unused_ok = ^{s_axi_awlen, s_axi_wdata[AXI_DATA_WIDTH-1:8]};

  assign aw_hs       = s_axi_awvalid && s_axi_awready;
  assign w_hs        = s_axi_wvalid && s_axi_wready;
  assign ar_hs       = s_axi_arvalid && s_axi_arready;
  assign ar_sel      = decode(32'(s_axi_araddr));
  assign status_beat = w_hs && (wr_sel == SEL_STATUS);

  assign s_axi_awready = (wr_state == W_IDLE);
  assign s_axi_wready  = (wr_state == W_DATA) && ((wr_sel != SEL_DATA) || !tx_full);
  assign s_axi_bvalid  = (wr_state == W_RESP);
  assign s_axi_bresp   = s_axi_bvalid ? bresp_q : RESP_OKAY;
  assign s_axi_arready = (rd_state == R_IDLE);
  assign s_axi_rvalid  = (rd_state == R_DATA);
  assign s_axi_rlast   = s_axi_rvalid;
  assign s_axi_rdata   = AXI_DATA_WIDTH'(rsp_q.data);
  assign s_axi_rresp   = rsp_q.resp;

  assign tx_push  = w_hs && (wr_sel == SEL_DATA);
  assign tx_flush = status_beat && s_axi_wdata[WB_FLUSH_TX];
  assign rx_flush = status_beat && s_axi_wdata[WB_FLUSH_RX];
  assign ovf_clr  = status_beat && s_axi_wdata[WB_CLR_OVF];
  assign rx_pop   = ar_hs && (ar_sel == SEL_DATA);
  assign tx_pop   = (tx_state == T_START);
  assign tx_start = (tx_state == T_START);
  assign tx_data  = tx_start ? tx_head : 8'h00;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .gclk(s_axi_aclk), .grst_n(s_axi_aresetn),
    .push(tx_push), .din(s_axi_wdata[7:0]), .pop(tx_pop), .flush(tx_flush),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .gclk(s_axi_aclk), .grst_n(s_axi_aresetn),
    .push(rx_ready), .din(rx_data), .pop(rx_pop), .flush(rx_flush),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // Read data is snapshotted at the AR handshake, so STATUS reflects that cycle.
  always_comb begin
    rsp_d = '0;
    case (ar_sel)
      SEL_DATA: if (!rx_empty) begin
        rsp_d.data[8]   = 1'b1;
        rsp_d.data[7:0] = rx_head;
      end
      SEL_STATUS: begin
        rsp_d.data[ST_TX_CNT +: 16] = 16'(tx_count);
        rsp_d.data[ST_RX_CNT +: 16] = 16'(rx_count);
        rsp_d.data[ST_TX_FULL]      = tx_full;
        rsp_d.data[ST_RX_EMPTY]     = rx_empty;
        rsp_d.data[ST_RX_OVF]       = rx_overflow;
      end
      default: rsp_d.resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    wr_next = wr_state;
    rd_next = rd_state;
    tx_next = tx_state;
    case (wr_state)
      W_IDLE:  if (aw_hs) wr_next = W_DATA;
      W_DATA:  if (w_hs && s_axi_wlast) wr_next = W_RESP;
      W_RESP:  if (s_axi_bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
    case (rd_state)
      R_IDLE: if (ar_hs) rd_next = R_DATA;
      R_DATA: if (s_axi_rready) rd_next = R_IDLE;
    endcase
    // The guard cycle covers the transmitter's latency in raising tx_busy.
    case (tx_state)
      T_IDLE:  if (!tx_empty && !tx_busy) tx_next = T_START;
      T_START: tx_next = T_GUARD;
      T_GUARD: tx_next = T_WAIT;
      T_WAIT:  if (!tx_busy) tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_state    <= W_IDLE;
      rd_state    <= R_IDLE;
      tx_state    <= T_IDLE;
      wr_sel      <= SEL_NONE;
      bresp_q     <= RESP_OKAY;
      rsp_q       <= '0;
      rx_overflow <= 1'b0;
    end else begin
      wr_state    <= wr_next;
      rd_state    <= rd_next;
      tx_state    <= tx_next;
      rx_overflow <= (rx_ready && rx_full) || (rx_overflow && !ovf_clr);
      if (aw_hs) begin
        wr_sel  <= decode(32'(s_axi_awaddr));
        bresp_q <= (decode(32'(s_axi_awaddr)) == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
      end
      if (ar_hs) rsp_q <= rsp_d;
    end
  end
endmodule

// File: tb/tb_axi2uart_fifo.sv
// Self-checking bench for axi2uart_fifo: TX byte scoreboard, read-response scoreboard and a read vector table.
module tb_axi2uart_fifo;
  localparam int AW  = 6;
  localparam int DW  = 128;
  localparam int TXD = 4;
  localparam int RXD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [7:0]    s_axi_awlen = '0;
  logic          s_axi_awvalid = 0, s_axi_awready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic          s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_wready;
  logic [1:0]    s_axi_bresp, s_axi_rresp;
  logic          s_axi_bvalid, s_axi_bready = 0;
  logic          s_axi_arvalid = 0, s_axi_arready;
  logic [DW-1:0] s_axi_rdata;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready = 0;
  logic          tx_start, tx_busy, rx_ready = 0;
  logic [7:0]    tx_data, rx_data = '0;

  axi2uart_fifo #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .rx_ready(rx_ready), .rx_data(rx_data)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_start = -1, busy_cnt = 0;
  logic force_busy = 1'b0;
  logic [AW-1:0] cur_waddr = '0;
  logic [7:0]    tx_exp[$];
  logic [DW-1:0] rd_exp[$];
  logic [1:0]    rr_exp[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rd_vec_t;
  rd_vec_t rtab[8];

  // Transmitter model: busy for 10 cycles after every start strobe.
  assign tx_busy = force_busy || (busy_cnt != 0);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_start) begin
      chk("tx_expected", DW'(tx_exp.size() != 0), DW'(1));
      if (tx_exp.size() != 0) chk("tx_data", DW'(tx_data), DW'(tx_exp.pop_front()));
      if (last_start >= 0) chk("tx_gap", DW'((cyc - last_start) >= 3), DW'(1));
      last_start <= cyc;
    end
  end

  function automatic logic [DW-1:0] st(input int txc, input int rxc, input bit txf, input bit rxe, input bit ovf);
    logic [DW-1:0] v = '0;
    v[15:0]  = txc[15:0];
    v[31:16] = rxc[15:0];
    v[32] = txf;
    v[33] = rxe;
    v[34] = ovf;
    return v;
  endfunction

  task automatic do_aw(input logic [AW-1:0] a, input logic [7:0] len);
    int to = 0;
    s_axi_awaddr = a; s_axi_awlen = len; s_axi_awvalid = 1; cur_waddr = a;
    while (!s_axi_awready && to < 100) begin @(negedge clk); to++; end
    chk("aw_ready", DW'(to < 100), DW'(1));
    @(negedge clk);
    s_axi_awvalid = 0;
  endtask

  task automatic do_beat(input logic [DW-1:0] d, input bit last);
    int to = 0;
    s_axi_wdata = d; s_axi_wlast = last; s_axi_wvalid = 1;
    while (!s_axi_wready && to < 2000) begin @(negedge clk); to++; end
    chk("w_ready", DW'(to < 2000), DW'(1));
    if (cur_waddr == '0 && to < 2000) tx_exp.push_back(d[7:0]);
    @(negedge clk);
    s_axi_wvalid = 0; s_axi_wlast = 0;
  endtask

  task automatic do_b(input int hold, input logic [1:0] exp);
    int to = 0;
    chk("b_latency", DW'(s_axi_bvalid), DW'(1));
    while (!s_axi_bvalid && to < 100) begin @(negedge clk); to++; end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("b_hold", DW'(s_axi_bvalid), DW'(1));
    end
    chk("bresp", DW'(s_axi_bresp), DW'(exp));
    s_axi_bready = 1;
    @(negedge clk);
    s_axi_bready = 0;
    chk("b_done", DW'(s_axi_bvalid), DW'(0));
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] ed, input logic [1:0] er);
    int to = 0;
    rd_exp.push_back(ed); rr_exp.push_back(er);
    s_axi_araddr = a; s_axi_arvalid = 1;
    while (!s_axi_arready && to < 100) begin @(negedge clk); to++; end
    @(negedge clk);
    s_axi_arvalid = 0;
    chk("r_latency", DW'(s_axi_rvalid), DW'(1));
    chk("rlast", DW'(s_axi_rlast), DW'(1));
    if (s_axi_rvalid) begin
      chk("rdata", s_axi_rdata, rd_exp.pop_front());
      chk("rresp", DW'(s_axi_rresp), DW'(rr_exp.pop_front()));
    end
    s_axi_rready = 1;
    @(negedge clk);
    s_axi_rready = 0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b; rx_ready = 1;
    @(negedge clk);
    rx_ready = 0;
  endtask

  task automatic wait_tx_drain();
    int to = 0;
    while (tx_exp.size() != 0 && to < 1000) begin @(negedge clk); to++; end
    chk("tx_drain", DW'(tx_exp.size()), DW'(0));
    repeat (15) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_awready"}, DW'(s_axi_awready), DW'(1));
    chk({tag, "_arready"}, DW'(s_axi_arready), DW'(1));
    chk({tag, "_wready"},  DW'(s_axi_wready),  DW'(0));
    chk({tag, "_bvalid"},  DW'(s_axi_bvalid),  DW'(0));
    chk({tag, "_rvalid"},  DW'(s_axi_rvalid),  DW'(0));
    chk({tag, "_rlast"},   DW'(s_axi_rlast),   DW'(0));
    chk({tag, "_tx_start"}, DW'(tx_start),     DW'(0));
    chk({tag, "_bresp"},   DW'(s_axi_bresp),   DW'(0));
    chk({tag, "_rresp"},   DW'(s_axi_rresp),   DW'(0));
    chk({tag, "_rdata"},   s_axi_rdata,        DW'(0));
    chk({tag, "_tx_data"}, DW'(tx_data),       DW'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rtab[0] = '{6'h10, st(0, 3, 0, 0, 0), 2'b00};
    rtab[1] = '{6'h00, DW'(12'h111), 2'b00};
    rtab[2] = '{6'h00, DW'(12'h122), 2'b00};
    rtab[3] = '{6'h00, DW'(12'h133), 2'b00};
    rtab[4] = '{6'h00, DW'(0), 2'b00};
    rtab[5] = '{6'h10, st(0, 0, 0, 1, 0), 2'b00};
    rtab[6] = '{6'h30, DW'(0), 2'b10};
    rtab[7] = '{6'h04, DW'(0), 2'b10};

    @(negedge clk);
    check_reset("por");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Four-byte burst, B held through five cycles of bready low.
    do_aw(6'h00, 8'd3);
    chk("aw_to_wready", DW'(s_axi_wready), DW'(1));
    for (int i = 0; i < 4; i++) do_beat(DW'(8'h41 + i), i == 3);
    do_b(5, 2'b00);
    wait_tx_drain();

    // Eight-beat burst into a 4-deep FIFO with the transmitter stalled.
    force_busy = 1;
    do_aw(6'h00, 8'd7);
    for (int i = 0; i < 4; i++) do_beat(DW'(8'h50 + i), 1'b0);
    repeat (3) begin
      chk("wready_full", DW'(s_axi_wready), DW'(0));
      @(negedge clk);
    end
    do_read(6'h10, st(4, 0, 1, 1, 0), 2'b00);
    force_busy = 0;
    for (int i = 4; i < 8; i++) do_beat(DW'(8'h50 + i), i == 7);
    do_b(0, 2'b00);
    wait_tx_drain();

    // Unmapped write: beats swallowed, SLVERR.
    do_aw(6'h30, 8'd1);
    do_beat(DW'(8'hAA), 1'b0);
    do_beat(DW'(8'hBB), 1'b1);
    do_b(0, 2'b10);

    rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33);
    for (int i = 0; i < 8; i++) do_read(rtab[i].addr, rtab[i].data, rtab[i].resp);

    // Overflow: the fifth byte is dropped and the sticky flag set, then cleared.
    for (int i = 0; i <= RXD; i++) rx_byte(8'hA0 + 8'(i));
    do_read(6'h10, st(0, 4, 0, 0, 1), 2'b00);
    do_aw(6'h10, 8'd0);
    do_beat(DW'(4), 1'b1);
    do_b(0, 2'b00);
    do_read(6'h10, st(0, 4, 0, 0, 0), 2'b00);
    for (int i = 0; i < 4; i++) do_read(6'h00, DW'(12'h1A0 + i), 2'b00);
    do_read(6'h00, DW'(0), 2'b00);

    // Asynchronous reset in the middle of a burst with a read response pending.
    force_busy = 1;
    do_aw(6'h00, 8'd3);
    do_beat(DW'(8'h61), 1'b0);
    do_beat(DW'(8'h62), 1'b0);
    do_read(6'h10, st(2, 0, 0, 1, 0), 2'b00);
    s_axi_araddr = 6'h10; s_axi_arvalid = 1;
    s_axi_wdata = DW'(8'h63); s_axi_wvalid = 1;
    @(posedge clk);
    #2;
    chk("pre_rst_rvalid", DW'(s_axi_rvalid), DW'(1));
    rst_n = 0;
    #1;
    check_reset("async");
    s_axi_arvalid = 0; s_axi_wvalid = 0;
    tx_exp.delete();
    force_busy = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_read(6'h10, st(0, 0, 0, 1, 0), 2'b00);
    repeat (30) @(negedge clk);

    chk("rd_scoreboard_empty", DW'(rd_exp.size()), DW'(0));
    chk("tx_scoreboard_empty", DW'(tx_exp.size()), DW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
